// File: rtl/freq_peak_search.sv
// freq_peak_search: scans the single-sided magnitude spectrum after the RAM
// write stage finishes and reports the two largest separated peaks.
module freq_peak_search #(
  parameter int ADDR_SPAN = 2048,
  parameter int SKIP_DC   = 2,
  parameter int MIN_SEP   = 4,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] rd_data,
  output logic        rd_en,
  output logic [11:0] rd_addr,
  output logic        busy,
  output logic        done,
  output logic [1:0]  peak_cnt,
  output logic [11:0] peak1_addr,
  output logic [15:0] peak1_mag,
  output logic [11:0] peak2_addr,
  output logic [15:0] peak2_mag
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [11:0] LP_FIRST = 12'(SKIP_DC - 1);
  localparam logic [11:0] LP_LAST  = 12'(ADDR_SPAN - 1);
  localparam logic [11:0] LP_SKIP  = 12'(SKIP_DC);
  localparam logic [11:0] LP_SEP   = 12'(MIN_SEP);
  localparam logic [1:0]  LP_DRAIN = 2'(RD_LAT);

  state_t            r_state;
  logic              r_start;
  logic              r_start_prev;
  logic [RD_LAT-1:0] r_vld;
  logic [15:0]       r_xm;       // x[k-1]
  logic [15:0]       r_x0;       // x[k]; rd_data supplies x[k+1]
  logic [11:0]       r_rx_addr;  // bin of the next sample to arrive
  logic [1:0]        r_drain;

  logic        w_start_edge;
  logic        w_vld;
  logic [11:0] w_kbin;
  logic [11:0] w_d;
  logic        w_cand;
  logic        w_gt1;
  logic        w_gt2;
  logic        w_far;

  // Candidate test on the window, evaluated while x[k+1] is on rd_data
  always_comb begin
    w_start_edge = r_start & ~r_start_prev;
    w_vld        = r_vld[RD_LAT-1];
    w_kbin       = r_rx_addr - 12'd1;
    w_d          = w_kbin - peak1_addr;
    w_cand       = w_vld && (w_kbin >= LP_SKIP) && (r_x0 > r_xm) && (r_x0 >= rd_data);
    w_gt1        = r_x0 > peak1_mag;
    w_gt2        = r_x0 > peak2_mag;
    w_far        = w_d >= LP_SEP;
  end

  // Read-valid pipeline matching the RAM latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= rd_en;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Scan FSM, sample window and peak registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_start      <= 1'b0;
      r_start_prev <= 1'b0;
      r_xm         <= '0;
      r_x0         <= '0;
      r_rx_addr    <= '0;
      r_drain      <= '0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      peak_cnt     <= '0;
      peak1_addr   <= '0;
      peak1_mag    <= '0;
      peak2_addr   <= '0;
      peak2_mag    <= '0;
    end else begin
      r_start      <= start;
      r_start_prev <= r_start;

      if (w_vld) begin
        r_xm      <= r_x0;
        r_x0      <= rd_data;
        r_rx_addr <= r_rx_addr + 12'd1;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_edge) begin
            r_state    <= S_READ;
            rd_en      <= 1'b1;
            rd_addr    <= LP_FIRST;
            r_rx_addr  <= LP_FIRST;
            busy       <= 1'b1;
            done       <= 1'b0;
            peak_cnt   <= '0;
            peak1_addr <= '0;
            peak1_mag  <= '0;
            peak2_addr <= '0;
            peak2_mag  <= '0;
          end
        end
        S_READ: begin
          if (rd_addr == LP_LAST) begin
            r_state <= S_DRAIN;
            rd_en   <= 1'b0;
            r_drain <= '0;
          end else begin
            rd_addr <= rd_addr + 12'd1;
          end
        end
        S_DRAIN: begin
          // Last sample lands RD_LAT clocks after the final read; one more
          // clock lets its candidate update settle before done rises.
          if (r_drain == LP_DRAIN) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            r_drain <= r_drain + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_cand && (r_state == S_READ || r_state == S_DRAIN)) begin
        if (w_gt1 && (peak_cnt == 2'd0 || w_far)) begin
          peak2_addr <= peak1_addr;
          peak2_mag  <= peak1_mag;
          peak1_addr <= w_kbin;
          peak1_mag  <= r_x0;
          peak_cnt   <= (peak_cnt == 2'd2) ? 2'd2 : peak_cnt + 2'd1;
        end else if (w_gt1) begin
          peak1_addr <= w_kbin;
          peak1_mag  <= r_x0;
        end else if (w_gt2 && w_far) begin
          peak2_addr <= w_kbin;
          peak2_mag  <= r_x0;
          peak_cnt   <= 2'd2;
        end
      end
    end
  end

endmodule

// File: doc/freq_peak_search.md
# freq_peak_search

Scans the single-sided FFT magnitude spectrum after the RAM write stage reports its write as complete. It finds the two largest separated spectral peaks and reports their bin addresses and magnitudes to the frequency-separation logic. It sits directly downstream of the magnitude RAM write controller. It uses the RAM read port and starts on that controller's `wr_done` level.

## Interface
Parameters:
- `ADDR_SPAN`, 2048: number of single-sided bins. Bins 0..ADDR_SPAN-1 are readable.
- `SKIP_DC`, 2: first candidate bin. Bins below it are never reported.
- `MIN_SEP`, 4: minimum bin distance between the two reported peaks.
- `RD_LAT`, 1: RAM read latency in clocks (1 or 2).

Ports:
- `clk` in 1: FFT clock, single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: level input, driven by the RAM write controller's `wr_done`.
- `rd_data` in 16: RAM read data, valid RD_LAT clocks after the matching `rd_en`.
- `rd_en` out 1: RAM read enable.
- `rd_addr` out 12: RAM read address.
- `busy` out 1: high while a scan is in progress.
- `done` out 1: level signal, high from scan completion until reset or the next scan.
- `peak_cnt` out 2: number of valid peaks found (0, 1 or 2).
- `peak1_addr` out 12, `peak1_mag` out 16: largest peak.
- `peak2_addr` out 12, `peak2_mag` out 16: second peak.

## Operation
- Reset value of every output is 0.
- State machine: IDLE -> READ -> DRAIN -> DONE.
- **Start:** on a rising edge of `start` (registered previous value 0, current value 1) in IDLE or DONE:
  - clear the peak registers and `peak_cnt`;
  - clear `done`;
  - enter READ.
- A `start` edge that arrives during READ or DRAIN is ignored.
- **READ:** `rd_en`=1. `rd_addr` steps by 1 each clock from SKIP_DC-1 to ADDR_SPAN-1, giving N = ADDR_SPAN-SKIP_DC+1 reads. After the last read the block enters DRAIN with `rd_en`=0 and `rd_addr` held.
- **Data window:** returned samples shift through a 3-deep window holding x[k-1], x[k], x[k+1]. The valid pipeline is RD_LAT deep and driven by `rd_en`.
- **Candidate test:** bin k is a candidate when x[k] > x[k-1] and x[k] >= x[k+1], for k in SKIP_DC..ADDR_SPAN-2.
  - Bin ADDR_SPAN-1 is never a candidate.
  - A zero magnitude can never be a candidate.
- **Peak update** for candidate (k, m), with d = k - peak1_addr (unsigned; scan order is ascending):
  - If m > peak1_mag and (peak_cnt=0 or d >= MIN_SEP): peak2 <= peak1, peak1 <= (k, m), peak_cnt <= min(peak_cnt+1, 2).
  - Else if m > peak1_mag and d < MIN_SEP: peak1 <= (k, m). peak2 and peak_cnt are unchanged.
  - Else if m > peak2_mag and d >= MIN_SEP: peak2 <= (k, m), peak_cnt <= 2.
  - Otherwise there is no change.
- **Ties:** comparisons are strict, so on equal magnitudes the lower bin wins.
- **DRAIN:** waits for the last sample and the final candidate update, then enters DONE. On entering DONE, `done` rises and `busy` falls.
- **DONE:** the peak outputs hold until reset or a new start edge.
- `rst_n` low at any time, including mid-scan, returns to IDLE with all outputs at 0. A scan interrupted by reset does not resume. Because `wr_done` is itself cleared by the same reset, the next scan needs a fresh `start` edge.

## Timing
- Let edge E be the clock that samples `start` rising.
- `busy` and `rd_en` rise at E+1.
- The first `rd_addr` is SKIP_DC-1 at E+1; the last is ADDR_SPAN-1 at E+N.
- `rd_en` falls at E+N+1.
- The candidate for bin k is evaluated in the clock in which x[k+1] arrives. Peak registers update on the following edge.
- `done` rises, `busy` falls and the final peak values are stable at E+N+RD_LAT+2. With the defaults this is E+2050.
- While `busy` is high, the peak outputs change only on candidate updates.

## Test plan
- **Single tone:** bin 100 = 5000, all other bins = 10 -> peak1 = (100, 5000), peak2 = (0, 0), peak_cnt = 1. `done` at E+2050.
- **Two tones:** bin 100 = 5000, bin 300 = 3000, others 10 -> peak1 = (100, 5000), peak2 = (300, 3000), peak_cnt = 2.
- **Separation rule:** bins 100 = 4000, 101 = 10, 102 = 5000, 500 = 1000, others 10 -> peak1 = (102, 5000), peak2 = (500, 1000), peak_cnt = 2. Bin 100 is never demoted to peak2.
- **DC, edge and tie handling:** bins 0 and 1 = 60000, bin 2047 = 9000, bins 200 and 400 = 3000, others 10 -> peak1 = (200, 3000), peak2 = (400, 3000).
- **Reset mid-scan:** pull `rst_n` low at E+500 -> all outputs 0 within the same cycle, `rd_en` = 0. Then release reset, give a new `start` edge and use the two-tone data -> full correct result at the new E+2050.
- **Start handling:** a second `start` edge during READ is ignored and timing is unchanged. A `start` edge while in DONE clears `done` at the next clock and rescans.
